// File: rtl/pong_ball_engine.sv
// Pong ball motion engine: tick-divided stepping, wall bounce, paddle hits with
// periodic speed-up, miss detection with score pulses and a post-score hold.
module pong_ball_engine #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_H     = 40,
  parameter int LEFT_PAD_X   = 100,
  parameter int RIGHT_PAD_X  = 540,
  parameter int TICK_DIV     = 262144,
  parameter int INIT_VX      = 5,
  parameter int INIT_VY      = 2,
  parameter int MAX_SPEED    = 7,
  parameter int SPEEDUP_HITS = 4,
  parameter int HOLD_TICKS   = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       serve,
  input  logic [9:0] left_paddle_y,
  input  logic [9:0] right_paddle_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       in_play,
  output logic       score_left,
  output logic       score_right
);

  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW    = $clog2(SPEEDUP_HITS + 1);
  localparam int HOLDW = $clog2(HOLD_TICKS + 1);

  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0]    HITS_TOP  = HW'(SPEEDUP_HITS);
  localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(HOLD_TICKS - 1);

  localparam logic [9:0] CX = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] CY = 10'((SCREEN_H - BALL_SIZE) / 2);

  localparam logic signed [11:0] BS_S    = 12'(BALL_SIZE);
  localparam logic signed [11:0] PH_S    = 12'(PADDLE_H);
  localparam logic signed [11:0] LPX_S   = 12'(LEFT_PAD_X);
  localparam logic signed [11:0] RPX_S   = 12'(RIGHT_PAD_X);
  localparam logic signed [11:0] XMAX_S  = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] YMAX_S  = 12'(SCREEN_H - BALL_SIZE);
  localparam logic signed [11:0] IVX_S   = 12'(INIT_VX);
  localparam logic signed [11:0] IVY_S   = 12'(INIT_VY);
  localparam logic signed [11:0] MAXV_S  = 12'(MAX_SPEED);

  typedef enum logic [1:0] {IDLE, PLAY, SCORED} state_t;

  state_t              r_state, w_state_next;
  logic [TW-1:0]       r_tick, w_tick_next;
  logic [9:0]          r_x, w_x_next;
  logic [9:0]          r_y, w_y_next;
  logic signed [11:0]  r_vx, w_vx_next;
  logic signed [11:0]  r_vy, w_vy_next;
  logic [HW-1:0]       r_hits, w_hits_next;
  logic [HOLDW-1:0]    r_hold, w_hold_next;
  logic                r_dir, w_dir_next;
  logic                r_in_play, r_score_left, r_score_right;
  logic                w_score_left_next, w_score_right_next;

  logic                w_step;
  logic signed [11:0]  w_xs, w_nx, w_ny, w_lpy, w_rpy;
  logic signed [11:0]  w_vx_mag, w_vx_mag_next, w_vx_bounce;
  logic [HW-1:0]       w_hits_inc;
  logic                w_speedup, w_hit_r, w_hit_l;

  assign w_step = enable && (r_tick == TICK_LAST);
  assign w_xs   = signed'({2'b00, r_x});
  assign w_nx   = w_xs + r_vx;
  assign w_ny   = signed'({2'b00, r_y}) + r_vy;
  assign w_lpy  = signed'({2'b00, left_paddle_y});
  assign w_rpy  = signed'({2'b00, right_paddle_y});

  assign w_hit_r = !r_vx[11] && (r_vx != 12'sd0) &&
                   (w_xs + BS_S <= RPX_S) && (w_nx + BS_S >= RPX_S) &&
                   (w_ny + BS_S > w_rpy) && (w_ny < w_rpy + PH_S);
  assign w_hit_l = r_vx[11] && (w_xs >= LPX_S) && (w_nx <= LPX_S) &&
                   (w_ny + BS_S > w_lpy) && (w_ny < w_lpy + PH_S);

  // Every SPEEDUP_HITS-th hit bumps |vx| before the direction is reversed.
  assign w_hits_inc    = r_hits + HW'(1);
  assign w_speedup     = (w_hits_inc == HITS_TOP);
  assign w_vx_mag      = r_vx[11] ? -r_vx : r_vx;
  assign w_vx_mag_next = (w_speedup && (w_vx_mag < MAXV_S)) ? w_vx_mag + 12'sd1 : w_vx_mag;
  assign w_vx_bounce   = r_vx[11] ? w_vx_mag_next : -w_vx_mag_next;

  always_comb begin
    w_state_next       = r_state;
    w_tick_next        = r_tick;
    w_x_next           = r_x;
    w_y_next           = r_y;
    w_vx_next          = r_vx;
    w_vy_next          = r_vy;
    w_hits_next        = r_hits;
    w_hold_next        = r_hold;
    w_dir_next         = r_dir;
    w_score_left_next  = 1'b0;
    w_score_right_next = 1'b0;

    if (enable) begin
      w_tick_next = w_step ? '0 : r_tick + TW'(1);
    end

    case (r_state)
      IDLE: begin
        if (enable && serve) begin
          w_state_next = PLAY;
          w_vx_next    = r_dir ? -IVX_S : IVX_S;
          w_vy_next    = IVY_S;
          w_dir_next   = ~r_dir;
          w_hits_next  = '0;
          w_tick_next  = '0;
        end
      end
      PLAY: begin
        if (w_step) begin
          if (w_ny <= 12'sd0) begin
            w_y_next  = 10'd0;
            w_vy_next = -r_vy;
          end else if (w_ny >= YMAX_S) begin
            w_y_next  = YMAX_S[9:0];
            w_vy_next = -r_vy;
          end else begin
            w_y_next  = w_ny[9:0];
          end

          if (w_hit_r || w_hit_l) begin
            w_x_next    = w_hit_r ? 10'(RIGHT_PAD_X - BALL_SIZE) : LPX_S[9:0];
            w_vx_next   = w_vx_bounce;
            w_hits_next = w_speedup ? '0 : w_hits_inc;
          end else if (w_nx >= XMAX_S) begin
            w_x_next          = XMAX_S[9:0];
            w_score_left_next = 1'b1;
            w_state_next      = SCORED;
            w_hold_next       = '0;
          end else if (w_nx <= 12'sd0) begin
            w_x_next           = 10'd0;
            w_score_right_next = 1'b1;
            w_state_next       = SCORED;
            w_hold_next        = '0;
          end else begin
            w_x_next = w_nx[9:0];
          end
        end
      end
      SCORED: begin
        if (w_step) begin
          if (r_hold == HOLD_LAST) begin
            w_state_next = IDLE;
            w_x_next     = CX;
            w_y_next     = CY;
          end else begin
            w_hold_next = r_hold + HOLDW'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_tick        <= '0;
      r_x           <= CX;
      r_y           <= CY;
      r_vx          <= '0;
      r_vy          <= '0;
      r_hits        <= '0;
      r_hold        <= '0;
      r_dir         <= 1'b0;
      r_in_play     <= 1'b0;
      r_score_left  <= 1'b0;
      r_score_right <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_tick        <= w_tick_next;
      r_x           <= w_x_next;
      r_y           <= w_y_next;
      r_vx          <= w_vx_next;
      r_vy          <= w_vy_next;
      r_hits        <= w_hits_next;
      r_hold        <= w_hold_next;
      r_dir         <= w_dir_next;
      r_in_play     <= (w_state_next == PLAY);
      r_score_left  <= w_score_left_next;
      r_score_right <= w_score_right_next;
    end
  end

  assign ball_x      = r_x;
  assign ball_y      = r_y;
  assign in_play     = r_in_play;
  assign score_left  = r_score_left;
  assign score_right = r_score_right;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Scoreboard bench for pong_ball_engine: stimulus queues cycle-stamped expected
// outputs, a negedge monitor pops and compares them as the cycles arrive.
module tb_pong_ball_engine;

  logic       clk = 1'b0;
  logic       reset, enable, serve;
  logic [9:0] left_paddle_y, right_paddle_y;
  logic [9:0] ball_x, ball_y;
  logic       in_play, score_left, score_right;

  logic       l_far = 1'b0;
  logic       r_far = 1'b0;
  logic [9:0] track_y;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int s1, s2, s3, s4;

  typedef struct {
    int         cyc;
    string      name;
    logic [9:0] x;
    logic [9:0] y;
    logic       ip;
    logic       sl;
    logic       sr;
  } exp_t;

  exp_t sb_q[$];

  pong_ball_engine #(.TICK_DIV(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .serve         (serve),
    .left_paddle_y (left_paddle_y),
    .right_paddle_y(right_paddle_y),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .in_play       (in_play),
    .score_left    (score_left),
    .score_right   (score_right)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Paddles follow the ball unless parked far away to force a miss.
  always_comb begin
    track_y        = (ball_y >= 10'd10) ? ball_y - 10'd10 : 10'd0;
    left_paddle_y  = l_far ? 10'd440 : track_y;
    right_paddle_y = r_far ? 10'd440 : track_y;
  end

  task automatic push(input int c, input string n, input int x, input int y,
                      input bit ip, input bit sl, input bit sr);
    exp_t e;
    e.cyc  = c;
    e.name = n;
    e.x    = 10'(x);
    e.y    = 10'(y);
    e.ip   = ip;
    e.sl   = sl;
    e.sr   = sr;
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   matched;
    matched = 1'b0;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s: check cycle %0d passed unsampled (now %0d)", e.name, e.cyc, cyc);
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      e = sb_q.pop_front();
      matched = 1'b1;
      n_tests++;
      if (ball_x !== e.x || ball_y !== e.y || in_play !== e.ip ||
          score_left !== e.sl || score_right !== e.sr) begin
        n_fail++;
        $display("[TB] FAIL %s @%0d: got x=%0d y=%0d ip=%b sl=%b sr=%b, want x=%0d y=%0d ip=%b sl=%b sr=%b",
                 e.name, cyc, ball_x, ball_y, in_play, score_left, score_right,
                 e.x, e.y, e.ip, e.sl, e.sr);
      end else begin
        $display("[TB] %-22s @%0d ok x=%0d y=%0d ip=%b sl=%b sr=%b",
                 e.name, cyc, ball_x, ball_y, in_play, score_left, score_right);
      end
    end
    if (!matched && (score_left === 1'b1 || score_right === 1'b1)) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL unexpected_score @%0d: got sl=%b sr=%b, want both 0",
               cyc, score_left, score_right);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: run did not complete, queue depth %0d", sb_q.size());
    $fatal(1, "watchdog timeout");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    serve  = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    push(3, "reset_state", 316, 236, 0, 0, 0);
    enable = 1'b0;
    push(4, "serve_while_disabled", 316, 236, 0, 0, 0);
    wait_cyc(4);
    enable = 1'b1;
    serve  = 1'b0;

    // Game 1: rightward serve, tracking paddles, speed-up to saturation, right miss
    wait_cyc(5);
    serve = 1'b1;
    s1 = cyc + 1;
    push(s1 + 0,   "serve1_launch",   316, 236, 1, 0, 0);
    push(s1 + 1,   "serve1_step",     321, 238, 1, 0, 0);
    push(s1 + 43,  "pre_hit1",        531, 322, 1, 0, 0);
    push(s1 + 44,  "hit1_right",      532, 324, 1, 0, 0);
    push(s1 + 45,  "after_hit1",      527, 326, 1, 0, 0);
    push(s1 + 117, "y_pre_top",       167, 470, 1, 0, 0);
    push(s1 + 118, "y_top_clamp",     162, 472, 1, 0, 0);
    push(s1 + 119, "y_after_top",     157, 470, 1, 0, 0);
    push(s1 + 130, "pre_hit2",        102, 448, 1, 0, 0);
    push(s1 + 131, "hit2_left",       100, 446, 1, 0, 0);
    push(s1 + 132, "after_hit2",      105, 444, 1, 0, 0);
    push(s1 + 217, "pre_hit3",        530, 274, 1, 0, 0);
    push(s1 + 218, "hit3_right",      532, 272, 1, 0, 0);
    push(s1 + 305, "hit4_left",       100,  98, 1, 0, 0);
    push(s1 + 306, "speed6",          106,  96, 1, 0, 0);
    push(s1 + 353, "y_pre_bottom",    388,   2, 1, 0, 0);
    push(s1 + 354, "y_bottom_clamp",  394,   0, 1, 0, 0);
    push(s1 + 355, "y_after_bottom",  400,   2, 1, 0, 0);
    push(s1 + 377, "hit5_right",      532,  46, 1, 0, 0);
    push(s1 + 378, "after_hit5",      526,  48, 1, 0, 0);
    push(s1 + 593, "hit8_left",       100, 466, 1, 0, 0);
    push(s1 + 594, "speed7",          107, 464, 1, 0, 0);
    push(s1 + 841, "hit12_left",      100,  30, 1, 0, 0);
    push(s1 + 842, "speed7_hold",     107,  32, 1, 0, 0);
    push(s1 + 916, "pre_miss_right",  625, 180, 1, 0, 0);
    push(s1 + 917, "miss_right",      632, 182, 0, 1, 0);
    push(s1 + 918, "score_pulse_end", 632, 182, 0, 0, 0);
    push(s1 + 976, "hold_frozen",     632, 182, 0, 0, 0);
    push(s1 + 977, "recentre",        316, 236, 0, 0, 0);
    wait_cyc(s1);
    serve = 1'b0;
    wait_cyc(s1 + 842);
    r_far = 1'b1;

    // Game 2: leftward serve, freeze with enable low, left miss
    wait_cyc(s1 + 980);
    r_far = 1'b0;
    l_far = 1'b1;
    serve = 1'b1;
    s2 = cyc + 1;
    push(s2 + 0,   "serve2_launch",   316, 236, 1, 0, 0);
    push(s2 + 1,   "serve2_leftward", 311, 238, 1, 0, 0);
    push(s2 + 2,   "serve2_step2",    306, 240, 1, 0, 0);
    push(s2 + 52,  "freeze_mid",      306, 240, 1, 0, 0);
    push(s2 + 102, "freeze_end",      306, 240, 1, 0, 0);
    push(s2 + 103, "resume",          301, 242, 1, 0, 0);
    push(s2 + 163, "pre_miss_left",     1, 362, 1, 0, 0);
    push(s2 + 164, "miss_left",         0, 364, 0, 0, 1);
    push(s2 + 165, "score_r_end",       0, 364, 0, 0, 0);
    wait_cyc(s2);
    serve = 1'b0;
    wait_cyc(s2 + 2);
    enable = 1'b0;
    wait_cyc(s2 + 102);
    enable = 1'b1;

    // Game 3: reset with serve mid-play, then serve direction restarts rightward
    wait_cyc(s2 + 230);
    serve = 1'b1;
    s3 = cyc + 1;
    s4 = s3 + 6;
    push(s3 + 0, "serve3_launch",     316, 236, 1, 0, 0);
    push(s3 + 1, "serve3_rightward",  321, 238, 1, 0, 0);
    push(s3 + 2, "serve3_step2",      326, 240, 1, 0, 0);
    push(s3 + 3, "reset_midplay",     316, 236, 0, 0, 0);
    push(s3 + 4, "idle_after_reset",  316, 236, 0, 0, 0);
    push(s4 + 0, "serve4_launch",     316, 236, 1, 0, 0);
    push(s4 + 1, "serve4_rightward",  321, 238, 1, 0, 0);
    wait_cyc(s3);
    serve = 1'b0;
    wait_cyc(s3 + 2);
    reset = 1'b1;
    serve = 1'b1;
    wait_cyc(s3 + 3);
    reset = 1'b0;
    serve = 1'b0;
    wait_cyc(s3 + 5);
    serve = 1'b1;
    wait_cyc(s4);
    serve = 1'b0;
    wait_cyc(s4 + 4);

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending checks, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_ball_engine.md
PONG_BALL_ENGINE -- requirements
Module: pong_ball_engine

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- BALL_SIZE, 8, ball square edge
- PADDLE_H, 40, paddle height
- LEFT_PAD_X, 100, x of left paddle's right face
- RIGHT_PAD_X, 540, x of right paddle's left face
- TICK_DIV, 262144, clocks per motion step (>=1)
- INIT_VX, 5, serve |vx|
- INIT_VY, 2, serve vy (signed)
- MAX_SPEED, 7, |vx| ceiling
- SPEEDUP_HITS, 4, paddle hits per |vx| increment
- HOLD_TICKS, 60, post-score pause in steps
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock
- reset, in, 1, synchronous, active-high
- enable, in, 1, high = game runs; low = freeze all state
- serve, in, 1, launch request
- left_paddle_y, in, 10, left paddle top y
- right_paddle_y, in, 10, right paddle top y
- ball_x, out, 10, ball left x
- ball_y, out, 10, ball top y
- in_play, out, 1, high in PLAY
- score_left, out, 1, one-cycle pulse: left player scores
- score_right, out, 1, one-cycle pulse: right player scores

Function
REQ-003 Tick counter SHALL count 0..TICK_DIV-1 while enable=1, asserting internal step on the cycle it equals TICK_DIV-1, then wrapping to 0; TICK_DIV=1 gives a step every enabled cycle.
REQ-004 enable=0 SHALL hold counter, FSM, position, velocity and hit count; score pulses stay 0.
REQ-005 FSM states SHALL be IDLE, PLAY, SCORED.
REQ-006 IDLE: ball at centre ((SCREEN_W-BALL_SIZE)/2, (SCREEN_H-BALL_SIZE)/2); serve=1 with enable=1 -> PLAY next cycle, vx=+/-INIT_VX by serve direction, vy=INIT_VY, hit count 0, tick counter 0.
REQ-007 Serve direction SHALL be rightward after reset and SHALL toggle on every serve.
REQ-008 PLAY: on each step compute nx=x+vx, ny=y+vy in signed 12-bit arithmetic; x and y axes resolve independently in the same step.
REQ-009 Y axis: ny<=0 -> y=0, vy=-vy; ny>=SCREEN_H-BALL_SIZE -> y=SCREEN_H-BALL_SIZE, vy=-vy; else y=ny.
REQ-010 Right paddle hit: vx>0, x+BALL_SIZE<=RIGHT_PAD_X, nx+BALL_SIZE>=RIGHT_PAD_X, and ny+BALL_SIZE>right_paddle_y and ny<right_paddle_y+PADDLE_H -> x=RIGHT_PAD_X-BALL_SIZE, vx=-vx.
REQ-011 Left paddle hit: vx<0, x>=LEFT_PAD_X, nx<=LEFT_PAD_X, same vertical overlap against left_paddle_y -> x=LEFT_PAD_X, vx=-vx.
REQ-012 Each paddle hit SHALL increment hit count; when count reaches SPEEDUP_HITS it resets to 0 and |vx| increases by 1, saturating at MAX_SPEED, sign preserved after reversal.
REQ-013 Miss: nx>=SCREEN_W-BALL_SIZE -> x=SCREEN_W-BALL_SIZE, score_left=1 for one cycle, -> SCORED; nx<=0 -> x=0, score_right=1 for one cycle, -> SCORED. Paddle hit takes priority over a miss in the same step.
REQ-014 No hit and no miss -> x=nx.
REQ-015 SCORED: ball frozen; after HOLD_TICKS steps -> IDLE (ball recentred); serve ignored in SCORED and PLAY.
REQ-016 in_play SHALL be 1 exactly in PLAY; all outputs registered.

Reset
REQ-017 reset=1 at a clock edge SHALL, regardless of state or enable, force IDLE, centre ball (316,236 at defaults), vx=vy=0, hit count 0, tick counter 0, serve direction rightward, in_play=0, score_left=score_right=0; reset dominates serve.

Verification (TICK_DIV=1, defaults otherwise)
REQ-018 Reset then serve -> next cycle in_play=1; after one step ball_x=321, ball_y=238.
REQ-019 Ball y=4, vy=-6 -> next step y=0, vy=+6; y=470, vy=+4 -> y=472, vy=-4.
REQ-020 Right approach x=530, vx=+5, right_paddle_y=ball_y-10 -> x=532, vx=-5, hit count 1; fourth hit -> |vx|=6; repeated to |vx|=7 holds at 7.
REQ-021 Right paddle far away, ball passes RIGHT_PAD_X -> x=632, score_left single-cycle pulse, in_play=0; 60 steps later ball at (316,236) in IDLE; next serve launches leftward.
REQ-022 enable=0 for 100 cycles mid-PLAY -> ball_x/ball_y unchanged; assert reset mid-PLAY with serve=1 -> IDLE, centre, no score pulse.
